// File: rtl/display_pkg.sv
// Shared constants and helpers for the six-digit multiplexed display scanner.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned POS_W      = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;
  localparam int unsigned LAST_POS   = NUM_DIGITS - 1;

  typedef logic [POS_W-1:0]              pos_t;
  typedef logic [DIGIT_W-1:0]            nibble_t;
  typedef logic [NUM_DIGITS*DIGIT_W-1:0] digits_t;
  typedef logic [NUM_DIGITS-1:0]         mask_t;

  // Select the nibble belonging to position p (0 for out-of-range positions).
  function automatic nibble_t digit_at(input digits_t d, input pos_t p);
    nibble_t r;
    r = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (p == pos_t'(i)) r = d[i*DIGIT_W +: DIGIT_W];
    end
    return r;
  endfunction

  // Select the blink-mask bit belonging to position p.
  function automatic logic mask_at(input mask_t m, input pos_t p);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (p == pos_t'(i)) r = m[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running clock prescaler: pulses step once every CLK_DIV enabled cycles.
module scan_prescaler #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic step
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Step fires on the cycle the counter sits at its terminal value.
  always_comb begin
    step = en && (cnt == CNT_LAST);
  end

  // Count while enabled, wrap at the terminal value, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == CNT_LAST) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan.sv
// Six-digit BCD display scanner with frame-synchronous input snapshot and blink.
// Optional build macro: DISPLAY_SCAN_LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit.
module display_scan
  import display_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          scan_en,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  output logic [POS_W-1:0]              bcd_pos,
  output logic [DIGIT_W-1:0]            bcd_digit,
  output logic                          frame
);

  localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

  logic              step;
  logic              wrap;
  pos_t              pos;
  digits_t           snap_digits;
  mask_t             snap_mask;
  logic [FCNT_W-1:0] fcnt;
  logic              blink_phase;
  logic              frame_q;
  nibble_t           nib;

  scan_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (scan_en),
    .step  (step)
  );

  // A wrap is the step that moves the scan from the last position back to 0.
  always_comb begin
    wrap = step && (pos == pos_t'(LAST_POS));
  end

  // Scan position, snapshot, frame pulse and blink timebase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos         <= '0;
      snap_digits <= '0;
      snap_mask   <= '0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      frame_q <= wrap;
      if (step) begin
        if (wrap) pos <= '0;
        else      pos <= pos + 1'b1;
      end
      if (wrap) begin
        snap_digits <= digits;
        snap_mask   <= blink_mask;
        if (fcnt == FCNT_LAST) begin
          fcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  // Output digit is muxed from registered state, so it moves with bcd_pos.
  always_comb begin
    nib = digit_at(snap_digits, pos);
`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
    if ((pos == pos_t'(LAST_POS)) && (nib == '0)) nib = BLANK_CODE;
`endif
    if (blink_phase && mask_at(snap_mask, pos)) nib = BLANK_CODE;
    bcd_digit = nib;
    bcd_pos   = pos;
    frame     = frame_q;
  end

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: directed table, corner sequences, random vs model.
module tb_display_scan;

  localparam int unsigned CLK_DIV      = 4;
  localparam int unsigned BLINK_FRAMES = 2;

`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
  localparam logic [3:0] LZ_EXP = 4'hF;
  localparam bit         LZ_ON  = 1'b1;
`else
  localparam logic [3:0] LZ_EXP = 4'h0;
  localparam bit         LZ_ON  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic [23:0] digits = '0;
  logic [5:0]  blink_mask = '0;
  logic [3:0]  bcd_pos;
  logic [3:0]  bcd_digit;
  logic        frame;

  int checks = 0;
  int errors = 0;

  display_scan #(
    .CLK_DIV      (CLK_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_en    (scan_en),
    .digits     (digits),
    .blink_mask (blink_mask),
    .bcd_pos    (bcd_pos),
    .bcd_digit  (bcd_digit),
    .frame      (frame)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference model: counts of enabled edges, steps and frames since reset.
  int unsigned m_e, m_s, m_f;
  logic [23:0] m_sd;
  logic [5:0]  m_sm;
  logic        m_fr;

  task automatic model_reset();
    m_e = 0; m_s = 0; m_f = 0; m_sd = '0; m_sm = '0; m_fr = 1'b0;
  endtask

  task automatic model_edge();
    m_fr = 1'b0;
    if (scan_en) begin
      m_e++;
      if (m_e % CLK_DIV == 0) begin
        m_s++;
        if (m_s % 6 == 0) begin
          m_f++;
          m_sd = digits;
          m_sm = blink_mask;
          m_fr = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [3:0] model_pos();
    return 4'(m_s % 6);
  endfunction

  function automatic logic [3:0] model_digit();
    int unsigned p;
    logic [3:0] n;
    p = m_s % 6;
    n = 4'((m_sd >> (4 * p)) & 24'hF);
    if (LZ_ON && p == 5 && n == 4'h0) n = 4'hF;
    if (((m_f / BLINK_FRAMES) % 2 == 1) && m_sm[p]) n = 4'hF;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] ep, input logic [3:0] ed, input logic ef);
    chk({name, ".pos"},   32'(bcd_pos),   32'(ep));
    chk({name, ".digit"}, 32'(bcd_digit), 32'(ed));
    chk({name, ".frame"}, 32'(frame),     32'(ef));
  endtask

  // One clock edge; model follows the inputs seen at that edge; returns 1ns after.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic        en;
    logic [23:0] dig;
    logic [5:0]  mask;
    int          n;
    logic [3:0]  epos;
    logic [3:0]  edig;
    logic        efr;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Comments give cumulative enabled edges since reset release (k).
    tbl[0]  = '{1'b1, 24'h123456, 6'b000000,  3, 4'd0, 4'h0,   1'b0}; // k=3
    tbl[1]  = '{1'b1, 24'h123456, 6'b000000,  1, 4'd1, 4'h0,   1'b0}; // k=4
    tbl[2]  = '{1'b1, 24'h123456, 6'b000000, 19, 4'd5, LZ_EXP, 1'b0}; // k=23 zero snapshot
    tbl[3]  = '{1'b1, 24'h123456, 6'b000000,  1, 4'd0, 4'h6,   1'b1}; // k=24 first capture
    tbl[4]  = '{1'b1, 24'h123456, 6'b000000,  1, 4'd0, 4'h6,   1'b0}; // k=25
    tbl[5]  = '{1'b1, 24'h123456, 6'b000000,  7, 4'd2, 4'h4,   1'b0}; // k=32
    tbl[6]  = '{1'b1, 24'h000000, 6'b000000,  8, 4'd4, 4'h2,   1'b0}; // k=40 old frame kept
    tbl[7]  = '{1'b1, 24'h000000, 6'b000000,  8, 4'd0, 4'h0,   1'b1}; // k=48 zeros now
    tbl[8]  = '{1'b0, 24'h000000, 6'b000000, 10, 4'd0, 4'h0,   1'b0}; // frozen
    tbl[9]  = '{1'b1, 24'h012345, 6'b000000, 24, 4'd0, 4'h5,   1'b1}; // k=72
    tbl[10] = '{1'b1, 24'h012345, 6'b000000, 20, 4'd5, LZ_EXP, 1'b0}; // k=92 leading zero
    tbl[11] = '{1'b1, 24'h012345, 6'b000011,  4, 4'd0, 4'h5,   1'b1}; // k=96 frame 4
    tbl[12] = '{1'b1, 24'h012345, 6'b000011, 24, 4'd0, 4'h5,   1'b1}; // k=120 frame 5
    tbl[13] = '{1'b1, 24'h012345, 6'b000011, 24, 4'd0, 4'hF,   1'b1}; // k=144 frame 6 blinks
    tbl[14] = '{1'b1, 24'h012345, 6'b000011,  4, 4'd1, 4'hF,   1'b0}; // k=148 pos1 blinks

    // Reset with asynchronous release away from the edge.
    model_reset();
    rst_n = 1'b0; scan_en = 1'b1; digits = 24'h123456; blink_mask = '0;
    #2;
    chk_out("reset_async", 4'd0, 4'h0, 1'b0);
    run(2);
    chk_out("reset_hold", 4'd0, 4'h0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      scan_en = tbl[i].en; digits = tbl[i].dig; blink_mask = tbl[i].mask;
      run(tbl[i].n);
      chk_out($sformatf("tbl%0d", i), tbl[i].epos, tbl[i].edig, tbl[i].efr);
    end

    // k=152: pos 2 of 012345 is 3, not in blink mask.
    run(4);
    chk_out("pos2_noblink", 4'd2, 4'h3, 1'b0);

    // Freeze at pos 3 with two prescaler counts remaining.
    run(6); // k=158
    chk_out("pre_freeze", 4'd3, 4'h2, 1'b0);
    scan_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out("freeze", 4'd3, 4'h2, 1'b0);
    end
    scan_en = 1'b1;
    tick(); // k=159
    chk_out("resume1", 4'd3, 4'h2, 1'b0);
    tick(); // k=160
    chk_out("resume2", 4'd4, 4'h1, 1'b0);

    // Asynchronous reset at pos 4, no clock edge in between.
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_out("async_rst", 4'd0, 4'h0, 1'b0);
    tick();
    rst_n = 1'b1;
    run(4);
    chk_out("restart_pos1", 4'd1, 4'h0, 1'b0);
    run(20);
    chk_out("restart_wrap", 4'd0, 4'h5, 1'b1);

    // Randomized run against the model, with occasional async resets.
    for (int i = 0; i < 1500; i++) begin
      scan_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) digits = 24'($urandom);
      if ($urandom_range(0, 7) == 0) blink_mask = 6'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_out("rand_rst", 4'd0, 4'h0, 1'b0);
        tick();
        rst_n = 1'b1;
      end
      tick();
      chk_out("rand", model_pos(), model_digit(), m_fr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
